mul_div_unit: RTL

Iterative multiply/divide unit for the CPU datapath, producing 64-bit products and quotient/remainder pairs over a fixed number of cycles. It sits in the execute stage beside the ALU. Its `lo_o` result drives input 2 of the write-back 3-to-1 result mux (select `2'b10`). `busy_o` is used by control to hold the PC while an operation is in flight.

---
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, with a one-cycle sign fix-up. Each operation takes WIDTH+2 cycles to done_o.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 sign1_q, sign1_d;
  logic                 sign2_q, sign2_d;
  logic [WIDTH-1:0]     src1_q, src1_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 in_sign1, in_sign2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    src1_d    = src1_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    in_sign1  = op_i[0] & src1_i[WIDTH-1];
    in_sign2  = op_i[0] & src2_i[WIDTH-1];
    mag1      = in_sign1 ? -src1_i : src1_i;
    mag2      = in_sign2 ? -src2_i : src2_i;
    mul_sum   = '0;
    div_trial = '0;
    prod      = '0;
    quot      = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          sign1_d = in_sign1;
          sign2_d = in_sign2;
          src1_d  = src1_i;
          // Multiply: multiplier shifts out of the low half. Divide: dividend shifts out.
          opb_d   = op_i[1] ? mag2 : mag1;
          acc_d   = {{WIDTH{1'b0}}, (op_i[1] ? mag1 : mag2)};
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!op_q[1]) begin
          mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
          acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
          if (!div_trial[WIDTH])
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1))
          state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q[1]) begin
          prod = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (opb_q == '0) begin
          // Divide by zero reports the untouched dividend, regardless of signedness.
          hi_d = src1_q;
          lo_d = '1;
        end else begin
          lo_d = (sign1_q ^ sign2_q) ? -quot : quot;
          hi_d = sign1_q ? -rem : rem;
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      src1_q  <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      src1_q  <= src1_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
